// File: rtl/score_pkg.sv
// Shared types and constants for the score display path: sprite record,
// glyph geometry and the per-side blink states.
package score_pkg;

    localparam int X_W        = 10;
    localparam int Y_W        = 10;
    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 8;
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
    localparam int COL_W      = $clog2(GLYPH_W);
    localparam int ROW_W      = $clog2(GLYPH_H);
    localparam int IDX_W      = $clog2(GLYPH_BITS);

    // score_val is row-major: bit row*GLYPH_W+col, row 0 at the top
    typedef struct packed {
        logic [X_W-1:0]        x_pos;
        logic [Y_W-1:0]        y_pos;
        logic [GLYPH_BITS-1:0] score_val;
    } score_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } blink_state_e;

    function automatic logic [IDX_W-1:0] glyph_index(input logic [ROW_W-1:0] row,
                                                      input logic [COL_W-1:0] col);
        return IDX_W'(row) * IDX_W'(GLYPH_W) + IDX_W'(col);
    endfunction

endpackage

// File: rtl/score_if.sv
// Score sprite bundle between the score controller and the display side.
interface score_if;
    import score_pkg::*;

    score_t player;
    score_t enemy;

    modport display_mp (input player, input enemy);
endinterface

// File: rtl/score_glyph_hit.sv
// One glyph sprite: stage-1 box test and cell address, stage-2 bitmap lookup.
module score_glyph_hit
    import score_pkg::*;
#(
    parameter int SCALE_LOG2 = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  score_t         glyph_i,
    input  logic [X_W-1:0] pix_x_i,
    input  logic [Y_W-1:0] pix_y_i,
    input  logic           visible_i,
    output logic           bit_o
);
    localparam int BOX_W = GLYPH_W << SCALE_LOG2;
    localparam int BOX_H = GLYPH_H << SCALE_LOG2;

    logic [X_W:0]       dx;
    logic [Y_W:0]       dy;
    logic               hit_d, hit_q;
    logic [COL_W-1:0]   col_d, col_q;
    logic [ROW_W-1:0]   row_d, row_q;
    logic               bit_d, bit_q;

    // Offsets are one bit wider so a box hanging past the screen edge never wraps
    always_comb begin
        dx    = {1'b0, pix_x_i} - {1'b0, glyph_i.x_pos};
        dy    = {1'b0, pix_y_i} - {1'b0, glyph_i.y_pos};
        hit_d = (pix_x_i >= glyph_i.x_pos) && (dx < (X_W+1)'(BOX_W)) &&
                (pix_y_i >= glyph_i.y_pos) && (dy < (Y_W+1)'(BOX_H));
        col_d = dx[SCALE_LOG2 +: COL_W];
        row_d = dy[SCALE_LOG2 +: ROW_W];
        bit_d = glyph_i.score_val[glyph_index(row_q, col_q)] & hit_q & visible_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_q <= 1'b0;
            col_q <= '0;
            row_q <= '0;
            bit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
            col_q <= col_d;
            row_q <= row_d;
            bit_q <= bit_d;
        end
    end

    assign bit_o = bit_q;

endmodule

// File: rtl/score_render.sv
// Rasterises the player/enemy score glyphs into a per-pixel "on" flag,
// with once-per-frame score snapshots and a blink after each score change.
module score_render
    import score_pkg::*;
#(
    parameter int SCALE_LOG2   = 2,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_HALF   = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           frame_start_i,
    input  logic           pix_valid_i,
    input  logic [X_W-1:0] pix_x_i,
    input  logic [Y_W-1:0] pix_y_i,
    score_if.display_mp    score_i,
    output logic           pix_valid_o,
    output logic           pix_on_o
);
    localparam int                CNT_W    = $clog2(BLINK_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BLINK_FRAMES - 1);

    score_t             shadow_q [2];
    blink_state_e       state_q  [2];
    blink_state_e       state_d  [2];
    logic [CNT_W-1:0]   cnt_q    [2];
    logic [CNT_W-1:0]   cnt_d    [2];
    logic [CNT_W-1:0]   elapsed  [2];
    logic [1:0]         changed;
    logic [1:0]         visible;
    logic [1:0]         side_bit;
    logic               valid1_q, valid2_q;

    always_comb begin
        changed[0] = frame_start_i && (score_i.player.score_val != shadow_q[0].score_val);
        changed[1] = frame_start_i && (score_i.enemy.score_val  != shadow_q[1].score_val);
    end

    // Blink counter counts frames remaining; visibility alternates every BLINK_HALF frames
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            state_d[s] = state_q[s];
            cnt_d[s]   = cnt_q[s];
            elapsed[s] = CNT_LOAD - cnt_q[s];
            visible[s] = 1'b1;
            case (state_q[s])
                IDLE: begin
                    if (changed[s]) begin
                        state_d[s] = BLINK;
                        cnt_d[s]   = CNT_LOAD;
                    end
                end
                BLINK: begin
                    visible[s] = ((int'(elapsed[s]) / BLINK_HALF) % 2) == 0;
                    if (changed[s]) begin
                        cnt_d[s] = CNT_LOAD;
                    end else if (frame_start_i) begin
                        if (cnt_q[s] != '0) cnt_d[s] = cnt_q[s] - 1'b1;
                        else                state_d[s] = IDLE;
                    end
                end
                default: state_d[s] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < 2; s++) begin
                shadow_q[s] <= '0;
                state_q[s]  <= IDLE;
                cnt_q[s]    <= '0;
            end
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
        end else begin
            if (frame_start_i) begin
                shadow_q[0] <= score_i.player;
                shadow_q[1] <= score_i.enemy;
            end
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= state_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
            valid1_q <= pix_valid_i;
            valid2_q <= valid1_q;
        end
    end

    score_glyph_hit #(.SCALE_LOG2(SCALE_LOG2)) u_player (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .glyph_i   (shadow_q[0]),
        .pix_x_i   (pix_x_i),
        .pix_y_i   (pix_y_i),
        .visible_i (visible[0]),
        .bit_o     (side_bit[0])
    );

    score_glyph_hit #(.SCALE_LOG2(SCALE_LOG2)) u_enemy (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .glyph_i   (shadow_q[1]),
        .pix_x_i   (pix_x_i),
        .pix_y_i   (pix_y_i),
        .visible_i (visible[1]),
        .bit_o     (side_bit[1])
    );

    assign pix_valid_o = valid2_q;
    assign pix_on_o    = (|side_bit) & valid2_q;

endmodule

// File: tb/tb_score_render.sv
// Directed bench for score_render, checked every cycle against a frame/pixel
// level model of glyph coverage, snapshots and blink timing.
module tb_score_render;
    import score_pkg::*;

    localparam int BLINK_FRAMES = 60;
    localparam int BLINK_HALF   = 8;
    localparam int SCALE        = 4;

    logic           clk         = 1'b0;
    logic           rstN        = 1'b0;
    logic           frameStart  = 1'b0;
    logic           pixValid    = 1'b0;
    logic [X_W-1:0] pixX        = '0;
    logic [Y_W-1:0] pixY        = '0;
    logic           pixValidOut;
    logic           pixOnOut;

    score_if scoreBus ();

    score_render #(
        .SCALE_LOG2   (2),
        .BLINK_FRAMES (BLINK_FRAMES),
        .BLINK_HALF   (BLINK_HALF)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .frame_start_i (frameStart),
        .pix_valid_i   (pixValid),
        .pix_x_i       (pixX),
        .pix_y_i       (pixY),
        .score_i       (scoreBus),
        .pix_valid_o   (pixValidOut),
        .pix_on_o      (pixOnOut)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: snapshot copies, frame counter, frame of last change per side
    score_t mShadow [2];
    int     frameCount = 0;
    int     lastChange [2] = '{-1000, -1000};
    logic   expOn1 = 1'b0, expOn2 = 1'b0, expValid1 = 1'b0, expValid2 = 1'b0;

    function automatic logic glyphPixel(input score_t g, input int px, input int py);
        int dx = px - int'(g.x_pos);
        int dy = py - int'(g.y_pos);
        if (dx < 0 || dy < 0 || dx >= GLYPH_W * SCALE || dy >= GLYPH_H * SCALE) return 1'b0;
        return g.score_val[(dy / SCALE) * GLYPH_W + (dx / SCALE)];
    endfunction

    function automatic logic sideVisible(input int s);
        int e = frameCount - lastChange[s];
        return (e >= BLINK_FRAMES) || ((e / BLINK_HALF) % 2 == 0);
    endfunction

    function automatic score_t mkScore(input int x, input int y, input logic [63:0] v);
        score_t r;
        r.x_pos     = X_W'(x);
        r.y_pos     = Y_W'(y);
        r.score_val = v;
        return r;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            expOn1      <= 1'b0;
            expOn2      <= 1'b0;
            expValid1   <= 1'b0;
            expValid2   <= 1'b0;
            mShadow[0]  <= '0;
            mShadow[1]  <= '0;
            lastChange  <= '{-1000, -1000};
        end else begin
            expOn2    <= expOn1;
            expValid2 <= expValid1;
            expValid1 <= pixValid;
            expOn1    <= pixValid &&
                         ((glyphPixel(mShadow[0], int'(pixX), int'(pixY)) && sideVisible(0)) ||
                          (glyphPixel(mShadow[1], int'(pixX), int'(pixY)) && sideVisible(1)));
            if (frameStart) begin
                frameCount <= frameCount + 1;
                if (scoreBus.player.score_val != mShadow[0].score_val) lastChange[0] <= frameCount + 1;
                if (scoreBus.enemy.score_val  != mShadow[1].score_val) lastChange[1] <= frameCount + 1;
                mShadow[0] <= scoreBus.player;
                mShadow[1] <= scoreBus.enemy;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("model pix_valid_o", pixValidOut, expValid2);
        checkOutput("model pix_on_o", pixOnOut, expOn2);
    end

    // All stimulus tasks are entered and left 1 time unit after a rising edge
    task automatic applyStimulus(input int x, input int y, input logic v);
        pixX     = X_W'(x);
        pixY     = Y_W'(y);
        pixValid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic probePixel(input string name, input int x, input int y, input logic exp);
        applyStimulus(x, y, 1'b1);
        applyStimulus(0, 0, 1'b0);
        checkOutput({name, " valid"}, pixValidOut, 1'b1);
        checkOutput(name, pixOnOut, exp);
    endtask

    task automatic pulseFrame();
        frameStart = 1'b1;
        pixValid   = 1'b0;
        @(posedge clk);
        #1;
        frameStart = 1'b0;
    endtask

    initial begin
        scoreBus.player = '0;
        scoreBus.enemy  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset pix_on_o", pixOnOut, 1'b0);
        checkOutput("reset pix_valid_o", pixValidOut, 1'b0);
        rstN = 1'b1;

        scoreBus.player = mkScore(100, 40, 64'h1);
        scoreBus.enemy  = mkScore(0, 0, 64'h0);
        pulseFrame();
        probePixel("bit0 origin", 100, 40, 1'b1);
        probePixel("left of box", 99, 40, 1'b0);
        probePixel("above box", 100, 39, 1'b0);
        probePixel("bit0 cell corner", 103, 43, 1'b1);
        probePixel("bit1 cell", 104, 40, 1'b0);

        scoreBus.player = mkScore(100, 40, 64'h8000_0000_0000_0000);
        probePixel("no snapshot old bit0", 100, 40, 1'b1);
        probePixel("no snapshot old bit63", 131, 71, 1'b0);
        pulseFrame();
        probePixel("bit63 corner", 131, 71, 1'b1);
        probePixel("right of box", 132, 71, 1'b0);
        probePixel("below box", 131, 72, 1'b0);
        probePixel("new shadow bit0", 100, 40, 1'b0);

        repeat (62) pulseFrame();
        probePixel("player settled", 131, 71, 1'b1);

        scoreBus.enemy = mkScore(200, 100, 64'hFFFF_FFFF_FFFF_FFFF);
        pulseFrame();
        for (int k = 0; k <= 64; k++) begin
            applyStimulus(200, 100, 1'b1);
            applyStimulus(0, 0, 1'b0);
            case (k)
                0, 7, 16, 60, 64: checkOutput("enemy visible half", pixOnOut, 1'b1);
                8, 15, 56, 59:    checkOutput("enemy hidden half", pixOnOut, 1'b0);
                default: ;
            endcase
            probePixel("player solid", 131, 71, 1'b1);
            pulseFrame();
        end

        scoreBus.enemy = mkScore(200, 100, 64'h1);
        pulseFrame();
        repeat (30) pulseFrame();
        probePixel("enemy frame 30", 200, 100, 1'b0);
        scoreBus.enemy = mkScore(200, 100, 64'h3);
        pulseFrame();
        for (int k = 0; k <= 60; k++) begin
            applyStimulus(200, 100, 1'b1);
            applyStimulus(0, 0, 1'b0);
            case (k)
                0, 60:      checkOutput("restart visible", pixOnOut, 1'b1);
                8, 40, 59:  checkOutput("restart hidden", pixOnOut, 1'b0);
                default: ;
            endcase
            pulseFrame();
        end

        applyStimulus(131, 71, 1'b1);
        applyStimulus(131, 71, 1'b1);
        applyStimulus(131, 71, 1'b1);
        checkOutput("in flight before reset", pixOnOut, 1'b1);
        rstN = 1'b0;
        #1;
        checkOutput("async reset pix_on_o", pixOnOut, 1'b0);
        checkOutput("async reset pix_valid_o", pixValidOut, 1'b0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        probePixel("after reset no shadow", 131, 71, 1'b0);
        pulseFrame();
        probePixel("after reset snapshot", 131, 71, 1'b1);

        scoreBus.player = mkScore(1016, 40, 64'hFFFF_FFFF_FFFF_FFFF);
        scoreBus.enemy  = mkScore(0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        pulseFrame();
        probePixel("no wrap x0", 0, 40, 1'b0);
        probePixel("no wrap x7", 7, 40, 1'b0);
        probePixel("no wrap x31", 31, 50, 1'b0);
        probePixel("edge glyph start", 1016, 40, 1'b1);
        probePixel("edge glyph last col", 1023, 71, 1'b1);
        probePixel("edge glyph below", 1023, 72, 1'b0);
        probePixel("origin glyph", 0, 0, 1'b1);
        probePixel("origin glyph corner", 31, 31, 1'b1);
        probePixel("origin glyph right", 32, 0, 1'b0);
        probePixel("origin glyph below", 0, 32, 1'b0);

        applyStimulus(0, 0, 1'b0);
        applyStimulus(0, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
